// File: rtl/apu_pkg.sv
// Shared APU definitions: address-frame marker, register-file size, write-FSM
// states and the length-register indices that fire channel events.
package apu_pkg;

  localparam logic [3:0] ADDR_MARKER = 4'b1000;
  localparam int         NUM_REGS    = 16;

  // Writes to a channel's last (length) register retrigger that channel.
  localparam logic [3:0] LEN_IDX_PULSE1   = 4'd3;
  localparam logic [3:0] LEN_IDX_PULSE2   = 4'd7;
  localparam logic [3:0] LEN_IDX_TRIANGLE = 4'd11;
  localparam logic [3:0] LEN_IDX_NOISE    = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } wr_state_t;

  function automatic logic [3:0] event_mask(input logic [3:0] idx);
    logic [3:0] m;
    m = 4'b0000;
    case (idx)
      LEN_IDX_PULSE1:   m = 4'b0001;
      LEN_IDX_PULSE2:   m = 4'b0010;
      LEN_IDX_TRIANGLE: m = 4'b0100;
      LEN_IDX_NOISE:    m = 4'b1000;
      default:          m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apu_reg_writer.sv
// UART-fed register front end: parses {8'b1000_aaaa, data} frames into a 16x8
// register file and strobes per-channel events on length-register writes.
module apu_reg_writer
  import apu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] regs_out,
  output logic [3:0]   reg_event,
  output logic [7:0]   err_count,
  output logic         busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; every
  // byte presented with rx_valid=1 is consumed on that clock edge.
  wr_state_t     state;
  logic [3:0]    addr_idx;
  logic [TW-1:0] timer;
  logic [7:0]    reg_file [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_idx  <= '0;
      timer     <= '0;
      reg_event <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= '0;
    end else begin
      reg_event <= '0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            if (rx_data[7:4] == ADDR_MARKER) begin
              addr_idx <= rx_data[3:0];
              timer    <= '0;
              state    <= DATA;
              busy     <= 1'b1;
            end else begin
              err_count <= sat_inc(err_count);
            end
          end
        end
        DATA: begin
          // A byte arriving on the expiry cycle still wins over the timeout.
          if (rx_valid) begin
            reg_file[addr_idx] <= rx_data;
            reg_event          <= event_mask(addr_idx);
            state              <= IDLE;
            busy               <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            err_count <= sat_inc(err_count);
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[8*g +: 8] = reg_file[g];
  end

endmodule

// File: tb/tb_apu_reg_writer.sv
// Bench for apu_reg_writer: directed vector table, hand-written timeout and reset
// sequences, and random byte streams checked against a frame-level model.
module tb_apu_reg_writer;

  localparam int T = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [127:0] regs_out;
  logic [3:0]   reg_event;
  logic [7:0]   err_count;
  logic         busy;

  apu_reg_writer #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .regs_out  (regs_out),
    .reg_event (reg_event),
    .err_count (err_count),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  // A data byte is accepted if it arrives within T cycles of its address byte;
  // reaching T cycles with nothing received drops the frame and counts an error.
  logic [7:0] m_regs [16];
  logic       m_have_addr;
  logic [3:0] m_idx;
  int         m_addr_cyc;
  int         m_err;
  logic [3:0] m_event;
  int         cyc;

  function automatic logic [3:0] chan_of(input logic [3:0] idx);
    case (idx)
      4'd3:    return 4'b0001;
      4'd7:    return 4'b0010;
      4'd11:   return 4'b0100;
      4'd15:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_have_addr = 1'b0;
    m_idx = 4'h0;
    m_addr_cyc = 0;
    m_err = 0;
    m_event = 4'h0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] d);
    m_event = 4'h0;
    if (m_have_addr) begin
      if (v) begin
        m_regs[m_idx] = d;
        m_event = chan_of(m_idx);
        m_have_addr = 1'b0;
      end else if (cyc - m_addr_cyc == T) begin
        m_have_addr = 1'b0;
        if (m_err < 255) m_err++;
      end
    end else if (v) begin
      if (d >= 8'h80 && d <= 8'h8F) begin
        m_have_addr = 1'b1;
        m_idx = d[3:0];
        m_addr_cyc = cyc;
      end else if (m_err < 255) begin
        m_err++;
      end
    end
  endtask

  task automatic model_check();
    logic [127:0] exp_regs;
    for (int i = 0; i < 16; i++) exp_regs[8*i +: 8] = m_regs[i];
    chk("regs_out", regs_out, exp_regs);
    chk("reg_event", {124'd0, reg_event}, {124'd0, m_event});
    chk("err_count", {120'd0, err_count}, 128'(m_err));
    chk("busy", {127'd0, busy}, {127'd0, m_have_addr});
  endtask

  // ---------------- drivers ----------------
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    cyc++;
    model_update(v, d);
    #1;
    model_check();
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Asserts reset away from the clock edge, checks the async clear, holds it
  // while rx_valid toggles, then releases on a falling edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_regs", regs_out, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    for (int i = 0; i < 4; i++) begin
      rx_valid = i[0];
      rx_data  = 8'h83;
      @(posedge clk);
      #1;
      chk("rst_hold_regs", regs_out, 128'd0);
      chk("rst_hold_event", {124'd0, reg_event}, 128'd0);
      chk("rst_hold_err", {120'd0, err_count}, 128'd0);
    end
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    model_check();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [3:0] idx;
    logic [7:0] exp_byte;
    logic [3:0] exp_ev;
    logic       exp_busy;
    logic [7:0] exp_err;
  } vec_t;

  vec_t tbl [16];
  logic [7:0] err_before;
  logic [7:0] reg0_before;

  initial begin
    tbl[0]  = '{1'b1, 8'h8E, 4'd14, 8'h00, 4'b0000, 1'b1, 8'd0};
    tbl[1]  = '{1'b1, 8'h05, 4'd14, 8'h05, 4'b0000, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 8'h8F, 4'd15, 8'h00, 4'b0000, 1'b1, 8'd0};
    tbl[3]  = '{1'b1, 8'hF8, 4'd15, 8'hF8, 4'b1000, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 8'h00, 4'd15, 8'hF8, 4'b0000, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 8'h12, 4'd3,  8'h00, 4'b0000, 1'b0, 8'd1};
    tbl[6]  = '{1'b1, 8'h7F, 4'd3,  8'h00, 4'b0000, 1'b0, 8'd2};
    tbl[7]  = '{1'b1, 8'h83, 4'd3,  8'h00, 4'b0000, 1'b1, 8'd2};
    tbl[8]  = '{1'b1, 8'h8C, 4'd3,  8'h8C, 4'b0001, 1'b0, 8'd2};
    tbl[9]  = '{1'b0, 8'h00, 4'd3,  8'h8C, 4'b0000, 1'b0, 8'd2};
    tbl[10] = '{1'b1, 8'h83, 4'd3,  8'h8C, 4'b0000, 1'b1, 8'd2};
    tbl[11] = '{1'b1, 8'h8C, 4'd3,  8'h8C, 4'b0001, 1'b0, 8'd2};
    tbl[12] = '{1'b1, 8'h85, 4'd5,  8'h00, 4'b0000, 1'b1, 8'd2};
    tbl[13] = '{1'b1, 8'h8A, 4'd5,  8'h8A, 4'b0000, 1'b0, 8'd2};
    tbl[14] = '{1'b1, 8'h87, 4'd7,  8'h00, 4'b0000, 1'b1, 8'd2};
    tbl[15] = '{1'b1, 8'h00, 4'd7,  8'h00, 4'b0010, 1'b0, 8'd2};

    cyc = 0;
    model_reset();
    @(posedge clk);
    do_reset();

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_byte", i), {120'd0, regs_out[8*tbl[i].idx +: 8]}, {120'd0, tbl[i].exp_byte});
      chk($sformatf("vec%0d_event", i), {124'd0, reg_event}, {124'd0, tbl[i].exp_ev});
      chk($sformatf("vec%0d_busy", i), {127'd0, busy}, {127'd0, tbl[i].exp_busy});
      chk($sformatf("vec%0d_err", i), {120'd0, err_count}, {120'd0, tbl[i].exp_err});
    end

    // Timeout: address with no data for T cycles drops the frame.
    err_before  = err_count;
    reg0_before = regs_out[7:0];
    step(1'b1, 8'h80);
    idle(T - 1);
    chk("to_busy_before", {127'd0, busy}, 128'd1);
    step(1'b0, 8'h00);
    chk("to_busy_after", {127'd0, busy}, 128'd0);
    chk("to_err", {120'd0, err_count}, {120'd0, err_before + 8'd1});
    chk("to_reg0", {120'd0, regs_out[7:0]}, {120'd0, reg0_before});
    step(1'b1, 8'h80);
    step(1'b1, 8'h11);
    chk("to_rewrite", {120'd0, regs_out[7:0]}, 128'h11);

    // Data byte on the expiry cycle is accepted with no error.
    err_before = err_count;
    step(1'b1, 8'h8B);
    idle(T - 1);
    step(1'b1, 8'h22);
    chk("exp_write", {120'd0, regs_out[95:88]}, 128'h22);
    chk("exp_event", {124'd0, reg_event}, 128'h4);
    chk("exp_err", {120'd0, err_count}, {120'd0, err_before});

    // Reset between address and data discards the frame.
    step(1'b1, 8'h84);
    do_reset();
    step(1'b1, 8'h55);
    chk("mid_rst_regs", regs_out, 128'd0);
    chk("mid_rst_busy", {127'd0, busy}, 128'd0);
    chk("mid_rst_err", {120'd0, err_count}, 128'd1);

    // Random byte stream, address-heavy, with occasional long gaps.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        idle($urandom_range(T - 3, T + 3));
      end else begin
        logic [7:0] b;
        b = ($urandom_range(0, 1) == 1) ? {4'h8, 4'($urandom_range(0, 15))}
                                        : 8'($urandom_range(0, 255));
        step($urandom_range(0, 2) != 0, b);
      end
    end

    // Saturation of the error counter.
    idle(T + 1);
    for (int i = 0; i < 300; i++) step(1'b1, 8'h3C);
    chk("sat_err", {120'd0, err_count}, 128'hFF);
    step(1'b1, 8'h00);
    chk("sat_hold", {120'd0, err_count}, 128'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
